// File: rtl/axi_slv_pkg.sv
// Shared types and constants for the AXI slave write path.
// Burst encodings, response codes and write-engine FSM states.
package axi_slv_pkg;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10,
        BURST_RSVD  = 2'b11
    } burst_e;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } resp_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_DATA = 2'b01,
        ST_RESP = 2'b10
    } wr_state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage : axi_slv_pkg

// File: rtl/axi_burst_addr_gen.sv
// Combinational AXI next-beat address generator (FIXED / INCR / WRAP).
// Reserved bursts step like INCR. Also flags a WRAP whose length is not
// 2, 4, 8 or 16 beats. Shared between the write engine and a future read engine.
module axi_burst_addr_gen
    import axi_slv_pkg::*;
#(
    parameter int ADDR_WIDTH = 32
) (
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [2:0]            i_size,
    input  logic [3:0]            i_len,
    input  burst_e                i_burst,
    output logic [ADDR_WIDTH-1:0] o_next_addr,
    output logic                  o_illegal_wrap
);

    localparam logic [ADDR_WIDTH-1:0] ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    logic [ADDR_WIDTH-1:0] w_incr;
    logic [ADDR_WIDTH-1:0] w_block;
    logic [ADDR_WIDTH-1:0] w_base;
    logic [ADDR_WIDTH-1:0] w_incr_next;
    logic [ADDR_WIDTH-1:0] w_wrap_next;

    // Bytes per beat, wrap block size and the aligned wrap base.
    assign w_incr      = ONE << i_size;
    assign w_block     = ({{(ADDR_WIDTH-4){1'b0}}, i_len} + ONE) * w_incr;
    assign w_base      = i_addr & ~(w_block - ONE);
    assign w_incr_next = (i_addr & ~(w_incr - ONE)) + w_incr;
    assign w_wrap_next = w_base | ((i_addr + w_incr) & (w_block - ONE));

    // Select the next beat address by burst type.
    always_comb begin
        o_next_addr = i_addr;
        case (i_burst)
            BURST_FIXED: o_next_addr = i_addr;
            BURST_INCR:  o_next_addr = w_incr_next;
            BURST_WRAP:  o_next_addr = w_wrap_next;
            BURST_RSVD:  o_next_addr = w_incr_next;
            default:     o_next_addr = i_addr;
        endcase
    end

    // WRAP is only legal for 2, 4, 8 or 16 beats.
    always_comb begin
        o_illegal_wrap = 1'b0;
        if (i_burst == BURST_WRAP) begin
            o_illegal_wrap = !((i_len == 4'd1) || (i_len == 4'd3) ||
                               (i_len == 4'd7) || (i_len == 4'd15));
        end else begin
            o_illegal_wrap = 1'b0;
        end
    end

endmodule : axi_burst_addr_gen

// File: rtl/axi_slv_wr_engine.sv
// AXI slave write-channel engine: one outstanding burst, AW -> W beats ->
// B response, beats written to a simple synchronous memory port.
// Optional macro AXI_SLV_WR_PROTO_CHK_EN adds WLAST/WID checking and the
// proto_err pulse output.
module axi_slv_wr_engine
    import axi_slv_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 4,
    parameter logic [ADDR_WIDTH-1:0] ADDR_LIMIT = 32'h0000_1000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ID_WIDTH-1:0]     AWID,
    input  logic [ADDR_WIDTH-1:0]   AWADDR,
    input  logic [3:0]              AWLEN,
    input  logic [2:0]              AWSIZE,
    input  logic [1:0]              AWBURST,
    input  logic                    AWVALID,
    output logic                    AWREADY,
    input  logic [ID_WIDTH-1:0]     WID,
    input  logic [DATA_WIDTH-1:0]   WDATA,
    input  logic [DATA_WIDTH/8-1:0] WSTRB,
    input  logic                    WLAST,
    input  logic                    WVALID,
    output logic                    WREADY,
    output logic [ID_WIDTH-1:0]     BID,
    output logic [1:0]              BRESP,
    output logic                    BVALID,
    input  logic                    BREADY,
    output logic                    mem_we,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
`ifdef AXI_SLV_WR_PROTO_CHK_EN
    output logic                    proto_err,
`endif
    output logic [DATA_WIDTH/8-1:0] mem_wstrb
);

    localparam logic [2:0] SIZE_MAX = 3'($clog2(DATA_WIDTH/8));

    wr_state_e               r_state;
    wr_state_e               w_state_nxt;
    logic [ID_WIDTH-1:0]     r_id;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [3:0]              r_len;
    logic [2:0]              r_size;
    burst_e                  r_burst;
    logic [3:0]              r_cnt;
    logic                    r_err;

    logic                    w_aw_hs;
    logic                    w_w_hs;
    logic                    w_b_hs;
    logic                    w_last_beat;
    logic                    w_addr_oor;
    logic                    w_dec_err;
    logic                    w_illegal_wrap;
    logic                    w_proto_bad;
    logic                    w_beat_err;
    logic [ADDR_WIDTH-1:0]   w_next_addr;

    axi_burst_addr_gen #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_addr_gen (
        .i_addr         (r_addr),
        .i_size         (r_size),
        .i_len          (r_len),
        .i_burst        (r_burst),
        .o_next_addr    (w_next_addr),
        .o_illegal_wrap (w_illegal_wrap)
    );

    assign w_aw_hs     = (r_state == ST_IDLE) && AWVALID && AWREADY;
    assign w_w_hs      = (r_state == ST_DATA) && WVALID && WREADY;
    assign w_b_hs      = (r_state == ST_RESP) && BVALID && BREADY;
    assign w_last_beat = (r_cnt == r_len);
    assign w_addr_oor  = (r_addr >= ADDR_LIMIT);
    // Decode errors depend only on the latched AW fields, so they are
    // re-evaluated on every beat and folded into the sticky flag.
    assign w_dec_err   = (r_burst == BURST_RSVD) || w_illegal_wrap || (r_size > SIZE_MAX);

`ifdef AXI_SLV_WR_PROTO_CHK_EN
    assign w_proto_bad = w_w_hs && ((WLAST != w_last_beat) || (WID != r_id));
`else
    // WLAST and WID carry no meaning when protocol checking is compiled out.
    logic w_unused_proto;
    assign w_unused_proto = ^{WID, WLAST};
    assign w_proto_bad    = 1'b0;
`endif

    assign w_beat_err = w_addr_oor || w_dec_err || w_proto_bad;

    // Next-state logic: burst count alone ends the DATA phase.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_aw_hs) begin
                    w_state_nxt = ST_DATA;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_DATA: begin
                if (w_w_hs && w_last_beat) begin
                    w_state_nxt = ST_RESP;
                end else begin
                    w_state_nxt = ST_DATA;
                end
            end
            ST_RESP: begin
                if (w_b_hs) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_RESP;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Burst context: latched AW fields, beat address/counter, sticky error.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_id    <= '0;
            r_addr  <= '0;
            r_len   <= 4'd0;
            r_size  <= 3'd0;
            r_burst <= BURST_FIXED;
            r_cnt   <= 4'd0;
            r_err   <= 1'b0;
        end else if (w_aw_hs) begin
            r_id    <= AWID;
            r_addr  <= AWADDR;
            r_len   <= AWLEN;
            r_size  <= AWSIZE;
            r_burst <= burst_e'(AWBURST);
            r_cnt   <= 4'd0;
            r_err   <= 1'b0;
        end else if (w_w_hs) begin
            r_addr  <= w_next_addr;
            r_cnt   <= r_cnt + 4'd1;
            r_err   <= r_err || w_beat_err;
        end
    end

    // Registered handshake readies follow the upcoming state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            AWREADY <= 1'b0;
            WREADY  <= 1'b0;
        end else begin
            AWREADY <= (w_state_nxt == ST_IDLE);
            WREADY  <= (w_state_nxt == ST_DATA);
        end
    end

    // Memory write port: one pulse per accepted beat, out-of-range beats masked.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wstrb <= '0;
        end else begin
            mem_we <= w_w_hs && !w_addr_oor;
            if (w_w_hs) begin
                mem_addr  <= r_addr;
                mem_wdata <= WDATA;
                mem_wstrb <= WSTRB;
            end
        end
    end

    // Write response: raised after the final beat, dropped on BREADY.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            BVALID <= 1'b0;
            BID    <= '0;
            BRESP  <= RESP_OKAY;
        end else if (w_w_hs && w_last_beat) begin
            BVALID <= 1'b1;
            BID    <= r_id;
            BRESP  <= (r_err || w_beat_err) ? RESP_SLVERR : RESP_OKAY;
        end else if (w_b_hs) begin
            BVALID <= 1'b0;
        end
    end

`ifdef AXI_SLV_WR_PROTO_CHK_EN
    // One-cycle protocol violation pulse aligned with the beat's write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            proto_err <= 1'b0;
        end else begin
            proto_err <= w_proto_bad;
        end
    end
`endif

endmodule : axi_slv_wr_engine

// File: tb/tb_axi_slv_wr_engine.sv
// Directed bench for axi_slv_wr_engine. With AXI_SLV_WR_PROTO_CHK_EN defined
// it also connects and exercises proto_err.
module tb_axi_slv_wr_engine;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  AWID;
    logic [31:0] AWADDR;
    logic [3:0]  AWLEN;
    logic [2:0]  AWSIZE;
    logic [1:0]  AWBURST;
    logic        AWVALID;
    logic        AWREADY;
    logic [3:0]  WID;
    logic [31:0] WDATA;
    logic [3:0]  WSTRB;
    logic        WLAST;
    logic        WVALID;
    logic        WREADY;
    logic [3:0]  BID;
    logic [1:0]  BRESP;
    logic        BVALID;
    logic        BREADY;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
`ifdef AXI_SLV_WR_PROTO_CHK_EN
    logic        proto_err;
`endif

    int errors = 0;
    int checks = 0;
    logic [3:0] wid_drv;

    axi_slv_wr_engine dut (
        .clk       (clk),
        .rst       (rst),
        .AWID      (AWID),
        .AWADDR    (AWADDR),
        .AWLEN     (AWLEN),
        .AWSIZE    (AWSIZE),
        .AWBURST   (AWBURST),
        .AWVALID   (AWVALID),
        .AWREADY   (AWREADY),
        .WID       (WID),
        .WDATA     (WDATA),
        .WSTRB     (WSTRB),
        .WLAST     (WLAST),
        .WVALID    (WVALID),
        .WREADY    (WREADY),
        .BID       (BID),
        .BRESP     (BRESP),
        .BVALID    (BVALID),
        .BREADY    (BREADY),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
`ifdef AXI_SLV_WR_PROTO_CHK_EN
        .proto_err (proto_err),
`endif
        .mem_wstrb (mem_wstrb)
    );

    always #5 clk = ~clk;

    // Advance one clock; sample 1ns after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send_aw(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
        AWID = id; AWADDR = addr; AWLEN = len; AWSIZE = size; AWBURST = burst;
        AWVALID = 1'b1;
        wid_drv = id;
        for (int k = 0; k < 20 && AWREADY !== 1'b1; k++) step();
        chk("aw_ready_wait", AWREADY, 1);
        step();
        AWVALID = 1'b0;
        chk("aw_ready_drop", AWREADY, 0);
        chk("w_ready_rise", WREADY, 1);
    endtask

    // exp_addr of all ones means the beat address is not checked.
    task automatic send_w(input string tag, input logic [31:0] data, input logic [3:0] strb,
                          input logic last, input logic exp_we, input logic [31:0] exp_addr);
        WDATA = data; WSTRB = strb; WLAST = last; WID = wid_drv; WVALID = 1'b1;
        for (int k = 0; k < 20 && WREADY !== 1'b1; k++) step();
        chk({tag, "_wready"}, WREADY, 1);
        step();
        WVALID = 1'b0; WLAST = 1'b0;
        chk({tag, "_we"}, mem_we, exp_we);
        if (exp_we && exp_addr != 32'hFFFF_FFFF) begin
            chk({tag, "_addr"}, mem_addr, exp_addr);
            chk({tag, "_data"}, mem_wdata, data);
            chk({tag, "_strb"}, mem_wstrb, strb);
        end
    endtask

    task automatic recv_b(input string tag, input logic [3:0] exp_id, input logic [1:0] exp_resp);
        chk({tag, "_bvalid"}, BVALID, 1);
        chk({tag, "_bid"}, BID, exp_id);
        chk({tag, "_bresp"}, BRESP, exp_resp);
        chk({tag, "_wready_low"}, WREADY, 0);
        BREADY = 1'b1;
        step();
        BREADY = 1'b0;
        chk({tag, "_bvalid_drop"}, BVALID, 0);
        chk({tag, "_awready_back"}, AWREADY, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; AWID = 4'd0; AWADDR = 32'd0; AWLEN = 4'd0; AWSIZE = 3'd0; AWBURST = 2'd0;
        AWVALID = 1'b0; WID = 4'd0; WDATA = 32'd0; WSTRB = 4'd0; WLAST = 1'b0; WVALID = 1'b0;
        BREADY = 1'b0; wid_drv = 4'd0;
        step(); step();
        chk("rst_awready", AWREADY, 0);
        chk("rst_wready", WREADY, 0);
        chk("rst_bvalid", BVALID, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_bid_bresp", {BID, BRESP}, 0);
        rst = 1'b0;
        step();
        chk("post_rst_awready", AWREADY, 1);

        // INCR, aligned
        send_aw(4'd5, 32'h100, 4'd3, 3'd2, 2'b01);
        send_w("incr_b0", 32'hA000_0000, 4'hF, 1'b0, 1'b1, 32'h100);
        send_w("incr_b1", 32'hA000_0001, 4'h3, 1'b0, 1'b1, 32'h104);
        send_w("incr_b2", 32'hA000_0002, 4'hF, 1'b0, 1'b1, 32'h108);
        send_w("incr_b3", 32'hA000_0003, 4'hC, 1'b1, 1'b1, 32'h10C);
        recv_b("incr_b", 4'd5, 2'b00);
        chk("incr_we_pulse", mem_we, 0);

        // INCR, unaligned first beat
        send_aw(4'd9, 32'h102, 4'd1, 3'd2, 2'b01);
        send_w("unal_b0", 32'h1111_2222, 4'hF, 1'b0, 1'b1, 32'h102);
        send_w("unal_b1", 32'h3333_4444, 4'hF, 1'b1, 1'b1, 32'h104);
        recv_b("unal_b", 4'd9, 2'b00);

        // WRAP
        send_aw(4'd2, 32'h38, 4'd3, 3'd2, 2'b10);
        send_w("wrap_b0", 32'hB0, 4'hF, 1'b0, 1'b1, 32'h38);
        send_w("wrap_b1", 32'hB1, 4'hF, 1'b0, 1'b1, 32'h3C);
        send_w("wrap_b2", 32'hB2, 4'hF, 1'b0, 1'b1, 32'h30);
        send_w("wrap_b3", 32'hB3, 4'hF, 1'b1, 1'b1, 32'h34);
        recv_b("wrap_b", 4'd2, 2'b00);

        // FIXED with BREADY backpressure
        send_aw(4'd7, 32'h20, 4'd2, 3'd2, 2'b00);
        send_w("fix_b0", 32'hC0, 4'hF, 1'b0, 1'b1, 32'h20);
        send_w("fix_b1", 32'hC1, 4'hF, 1'b0, 1'b1, 32'h20);
        send_w("fix_b2", 32'hC2, 4'hF, 1'b1, 1'b1, 32'h20);
        for (int c = 0; c < 5; c++) begin
            chk("bp_bvalid", BVALID, 1);
            chk("bp_bid_bresp", {BID, BRESP}, {4'd7, 2'b00});
            chk("bp_awready", AWREADY, 0);
            step();
        end
        recv_b("fix_b", 4'd7, 2'b00);

        // Out-of-range second beat
        send_aw(4'd1, 32'hFFC, 4'd1, 3'd2, 2'b01);
        send_w("oor_b0", 32'hD0, 4'hF, 1'b0, 1'b1, 32'hFFC);
        send_w("oor_b1", 32'hD1, 4'hF, 1'b1, 1'b0, 32'h1000);
        recv_b("oor_b", 4'd1, 2'b10);

        // Reserved burst: stepped like INCR, SLVERR
        send_aw(4'd4, 32'h200, 4'd1, 3'd2, 2'b11);
        send_w("rsv_b0", 32'hE0, 4'hF, 1'b0, 1'b1, 32'h200);
        send_w("rsv_b1", 32'hE1, 4'hF, 1'b1, 1'b1, 32'h204);
        recv_b("rsv_b", 4'd4, 2'b10);

        // Oversize beat
        send_aw(4'd3, 32'h80, 4'd0, 3'd3, 2'b01);
        send_w("size_b0", 32'hF0, 4'hF, 1'b1, 1'b1, 32'h80);
        recv_b("size_b", 4'd3, 2'b10);

        // WRAP with illegal length (3 beats)
        send_aw(4'd8, 32'h8, 4'd2, 3'd2, 2'b10);
        send_w("iwrap_b0", 32'h90, 4'hF, 1'b0, 1'b1, 32'h8);
        send_w("iwrap_b1", 32'h91, 4'hF, 1'b0, 1'b1, 32'hFFFF_FFFF);
        send_w("iwrap_b2", 32'h92, 4'hF, 1'b1, 1'b1, 32'hFFFF_FFFF);
        recv_b("iwrap_b", 4'd8, 2'b10);

        // Reset in the middle of an 8-beat burst
        send_aw(4'd6, 32'h300, 4'd7, 3'd2, 2'b01);
        send_w("mid_b0", 32'h70, 4'hF, 1'b0, 1'b1, 32'h300);
        send_w("mid_b1", 32'h71, 4'hF, 1'b0, 1'b1, 32'h304);
        rst = 1'b1;
        #1;
        chk("midrst_outs", {AWREADY, WREADY, BVALID, mem_we}, 0);
        chk("midrst_addr", mem_addr, 0);
        chk("midrst_bid_bresp", {BID, BRESP}, 0);
        step();
        rst = 1'b0;
        step();
        chk("midrst_awready", AWREADY, 1);
        chk("midrst_no_b", BVALID, 0);
        send_aw(4'd10, 32'h40, 4'd0, 3'd2, 2'b01);
        send_w("after_b0", 32'h55AA_55AA, 4'hF, 1'b1, 1'b1, 32'h40);
        recv_b("after_b", 4'd10, 2'b00);

`ifdef AXI_SLV_WR_PROTO_CHK_EN
        // Early WLAST and mismatched WID on beat 1
        send_aw(4'd1, 32'h0, 4'd3, 3'd2, 2'b01);
        send_w("pc_b0", 32'h60, 4'hF, 1'b0, 1'b1, 32'h0);
        chk("pc_b0_perr", proto_err, 0);
        wid_drv = 4'd2;
        send_w("pc_b1", 32'h61, 4'hF, 1'b1, 1'b1, 32'h4);
        chk("pc_b1_perr", proto_err, 1);
        wid_drv = 4'd1;
        send_w("pc_b2", 32'h62, 4'hF, 1'b0, 1'b1, 32'h8);
        chk("pc_b2_perr", proto_err, 0);
        send_w("pc_b3", 32'h63, 4'hF, 1'b1, 1'b1, 32'hC);
        chk("pc_b3_perr", proto_err, 0);
        recv_b("pc_b", 4'd1, 2'b10);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_axi_slv_wr_engine

// File: doc/axi_slv_wr_engine.md
Name: axi_slv_wr_engine

Overview:
- RTL write-channel engine for the AXI slave side; sits directly downstream of the AXI slave interface and is the DUT that the slave driver's write path exercises.
- Accepts AW bursts and W beats, generates per-beat addresses (FIXED/INCR/WRAP) and drives a simple synchronous memory write port.
- Returns one B response per burst, with SLVERR on decode or protocol violations.
- Single outstanding write transaction.

Parameters:
- ADDR_WIDTH, 32, address bus width
- DATA_WIDTH, 32, write data width; WSTRB width is DATA_WIDTH/8
- ID_WIDTH, 4, AWID/WID/BID width
- ADDR_LIMIT, 32'h0000_1000, byte addresses >= ADDR_LIMIT are out of range

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous active-high reset
- AWID  input  ID_WIDTH  write address ID
- AWADDR  input  ADDR_WIDTH  burst start byte address
- AWLEN  input  4  beats minus one
- AWSIZE  input  3  log2 bytes per beat
- AWBURST  input  2  00 FIXED, 01 INCR, 10 WRAP, 11 reserved
- AWVALID  input  1  address valid
- AWREADY  output  1  address ready
- WID  input  ID_WIDTH  write data ID
- WDATA  input  DATA_WIDTH  write data
- WSTRB  input  DATA_WIDTH/8  byte strobes
- WLAST  input  1  last beat flag
- WVALID  input  1  data valid
- WREADY  output  1  data ready
- BID  output  ID_WIDTH  response ID
- BRESP  output  2  00 OKAY, 10 SLVERR
- BVALID  output  1  response valid
- BREADY  input  1  response ready
- mem_we  output  1  memory write enable, one-cycle pulse
- mem_addr  output  ADDR_WIDTH  beat byte address
- mem_wdata  output  DATA_WIDTH  beat data
- mem_wstrb  output  DATA_WIDTH/8  beat strobes

Behaviour:
- Clock/reset: one clock clk; reset rst is asynchronous, active-high. On rst, all outputs are 0 and the FSM is in IDLE.
- Reset mid-burst: the burst is abandoned and no B response is issued.
- FSM states: IDLE -> DATA -> RESP -> IDLE. All outputs are registered.
- IDLE:
  - AWREADY=1, first asserted in the first cycle after rst deasserts.
  - On AWVALID&AWREADY: latch ID, address, len, size and burst; clear the beat counter and error flag; deassert AWREADY; next state is DATA.
- DATA:
  - WREADY=1.
  - Each WVALID&WREADY registers mem_we=1 with mem_addr (current beat address), mem_wdata and mem_wstrb. The write appears one cycle after the handshake.
  - After each handshake, the beat address advances and the beat counter increments.
  - When the beat counter equals the latched len, deassert WREADY; next state is RESP.
  - Termination is by beat count only; WLAST does not end the burst.
- Address generation, with incr = 1<<size:
  - FIXED: address is unchanged.
  - INCR: next = (addr & ~(incr-1)) + incr; the first beat may be unaligned.
  - WRAP: block = (len+1)*incr; next = base | ((addr+incr) & (block-1)), where base = addr & ~(block-1). WRAP requires len in {1,3,7,15}.
  - Arithmetic is modulo 2^ADDR_WIDTH.
- Error flag is sticky per burst and is set by any of:
  - reserved burst (11), which is otherwise handled as INCR;
  - WRAP with an illegal len;
  - AWSIZE > log2(DATA_WIDTH/8);
  - any beat address >= ADDR_LIMIT. The offending beat gets mem_we=0; other beats are still written.
- RESP:
  - BVALID=1, BID = latched ID, BRESP = SLVERR if the error flag is set, else OKAY.
  - Hold until BREADY; the handshake clears BVALID; next state is IDLE.
  - BREADY already high: BVALID stays high for exactly one cycle.
- Minimum burst cost: 1 AW cycle + (len+1) W cycles + 1 B cycle. The earliest next AWREADY comes the cycle after the B handshake.
- W beats presented while in IDLE are not accepted (WREADY=0).

Optional Feature:
- Macro: AXI_SLV_WR_PROTO_CHK_EN.
- Defined:
  - Setting WLAST on a beat other than the final beat sets the error flag.
  - Missing WLAST on the final beat sets the error flag.
  - WID != latched AWID on any beat sets the error flag.
  - Output proto_err (1 bit) pulses for one cycle per violating beat.
- Undefined: WLAST and WID are ignored; proto_err does not exist. BRESP then depends only on decode and burst checks.

Decomposition:
- Package axi_slv_pkg: burst_e (FIXED/INCR/WRAP/RSVD), resp_e (OKAY/EXOKAY/SLVERR/DECERR), wr_state_e (IDLE/DATA/RESP), RESP_OKAY/RESP_SLVERR constants.
- Sub-module axi_burst_addr_gen: combinational next-beat address from addr, size, len and burst, plus an illegal-wrap flag. It is reused by a future read engine.

Test Plan:
- INCR burst: AWADDR=0x100, AWLEN=3, AWSIZE=2, AWID=5; 4 beats, WLAST on beat 3 -> mem_addr 0x100, 0x104, 0x108, 0x10C; BID=5, BRESP=00.
- WRAP burst: AWADDR=0x38, AWLEN=3, AWSIZE=2 -> mem_addr 0x38, 0x3C, 0x30, 0x34; BRESP=00.
- FIXED burst: AWADDR=0x20, AWLEN=2 -> 3 writes, all to 0x20. Out-of-range burst: AWADDR=0xFFC, AWLEN=1, INCR -> write at 0xFFC only, beat at 0x1000 suppressed; BRESP=10.
- Backpressure: BREADY held low for 5 cycles -> BVALID/BID/BRESP stable; AWREADY=0 throughout; AWREADY=1 the cycle after the B handshake.
- Reset mid-burst: rst asserted after beat 1 of AWLEN=7 -> all outputs 0 immediately; after release, a new AWLEN=0 burst completes with BRESP=00.
- With AXI_SLV_WR_PROTO_CHK_EN: WLAST on beat 1 of AWLEN=3 plus WID=2 vs AWID=1 -> proto_err pulses; all 4 beats written; BRESP=10.
